// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side binary/Gray pointer and registered full flag for an async FIFO.
// Optional WPTR_LEVEL_EN adds a registered write-side fill level and almost-full flag.
module fifo_wptr_full #(
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rptr_gray_sync,
    output logic [ADDR_W-1:0] waddr,
    output logic              wr_fire,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full
`ifdef WPTR_LEVEL_EN
    ,
    output logic [ADDR_W:0]   wlevel,
    output logic              almost_full
`endif
);
    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] bnext;
    logic [ADDR_W:0] gnext;
    logic [ADDR_W:0] rfull;

    assign wr_fire = wr_en & ~full;
    assign bnext   = wbin + {{ADDR_W{1'b0}}, wr_fire};
    assign gnext   = (bnext >> 1) ^ bnext;
    assign waddr   = wbin[ADDR_W-1:0];
    // Gray code of rptr + depth: the two MSBs invert, the rest match
    assign rfull   = {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
        end else begin
            wbin      <= bnext;
            wptr_gray <= gnext;
            full      <= (gnext == rfull);
        end
    end

`ifdef WPTR_LEVEL_EN
    localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'((2 ** ADDR_W) - AF_MARGIN);
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] diff;

    for (genvar i = 0; i <= ADDR_W; i++) begin : g_rbin
        assign rbin[i] = ^rptr_gray_sync[ADDR_W:i];
    end

    assign diff = bnext - rbin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wlevel      <= '0;
            almost_full <= 1'b0;
        end else begin
            wlevel      <= diff;
            almost_full <= (diff >= AF_TH);
        end
    end
`else
    logic unused_af;
    assign unused_af = (AF_MARGIN > 0);
`endif
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: randomized and directed check of fifo_wptr_full (ADDR_W=2) against a count-based model.
module tb_fifo_wptr_full;
    localparam int AW = 2;
    localparam int AF = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW:0]   rb = '0;
    logic [AW:0]   rptr_gray_sync;
    logic [AW-1:0] waddr;
    logic          wr_fire;
    logic [AW:0]   wptr_gray;
    logic          full;
`ifdef WPTR_LEVEL_EN
    logic [AW:0]   wlevel;
    logic          almost_full;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    assign rptr_gray_sync = rb ^ (rb >> 1);

    fifo_wptr_full #(.ADDR_W(AW), .AF_MARGIN(AF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .rptr_gray_sync(rptr_gray_sync),
        .waddr(waddr),
        .wr_fire(wr_fire),
        .wptr_gray(wptr_gray),
        .full(full)
`ifdef WPTR_LEVEL_EN
        ,
        .wlevel(wlevel),
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    // Model: number of accepted writes (mod 8) and the read count, full when they differ by the depth
    logic [AW:0] m_w;
    logic        m_full;
    logic        m_acc;
    logic [AW:0] m_wn;
    logic [AW:0] m_lvl;
    logic        m_af;

    assign m_acc = wr_en & ~m_full;
    assign m_wn  = m_w + {{AW{1'b0}}, m_acc};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_w    <= '0;
            m_full <= 1'b0;
            m_lvl  <= '0;
            m_af   <= 1'b0;
        end else begin
            m_w    <= m_wn;
            m_full <= ((m_wn - rb) == 3'd4);
            m_lvl  <= m_wn - rb;
            m_af   <= (int'(3'(m_wn - rb)) >= 4 - AF);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("waddr", int'(waddr), int'(m_w % 4));
        chk("wptr_gray", int'(wptr_gray), int'(m_w ^ (m_w >> 1)));
        chk("full", int'(full), int'(m_full));
        chk("wr_fire", int'(wr_fire), int'(wr_en & ~m_full));
`ifdef WPTR_LEVEL_EN
        chk("wlevel", int'(wlevel), int'(m_lvl));
        chk("almost_full", int'(almost_full), int'(m_af));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rb = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_gray", int'(wptr_gray), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_fire", int'(wr_fire), 0);
        step();
        rst_n = 1'b1;
    endtask

    int gseq[4] = '{1, 3, 2, 6};

    initial begin
        step();
        do_reset();
        // fill from empty
        wr_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_waddr", int'(waddr), k);
            chk("fill_fire", int'(wr_fire), 1);
            step();
            chk("fill_gray", int'(wptr_gray), gseq[k]);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_reject", int'(wr_fire), 0);
        step();
        chk("fill_hold", int'(wptr_gray), 6);
        // drain one, refill
        wr_en = 1'b0;
        rb = 3'd1;
        step();
        chk("drain_full", int'(full), 0);
        wr_en = 1'b1;
        #1;
        chk("drain_fire", int'(wr_fire), 1);
        step();
        chk("refill_gray", int'(wptr_gray), 7);
        chk("refill_full", int'(full), 1);
        // asynchronous reset mid-cycle, then wrap-around with reader trailing by one
        #2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            rb = 3'(i);
            step();
            chk("wrap_full", int'(full), 0);
        end
        chk("wrap_gray", int'(wptr_gray), 0);
        chk("wrap_waddr", int'(waddr), 0);
        // full, then read advances while a write is requested
        rb = 3'd7;
        repeat (3) step();
        chk("sim_full", int'(full), 1);
        rb = 3'd0;
        #1;
        chk("sim_reject", int'(wr_fire), 0);
        step();
        chk("sim_gray_hold", int'(wptr_gray), 2);
        chk("sim_unfull", int'(full), 0);
        chk("sim_accept", int'(wr_fire), 1);
        step();
        chk("sim_gray", int'(wptr_gray), 6);
        chk("sim_refull", int'(full), 1);
`ifdef WPTR_LEVEL_EN
        do_reset();
        wr_en = 1'b1;
        repeat (3) step();
        chk("lvl3", int'(wlevel), 3);
        chk("af3", int'(almost_full), 1);
        step();
        chk("lvl4", int'(wlevel), 4);
        chk("full4", int'(full), 1);
        wr_en = 1'b0;
        rb = 3'd2;
        step();
        chk("lvl2", int'(wlevel), 2);
        chk("af2", int'(almost_full), 0);
`endif
        // random traffic with a reader that never passes the writer
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step();
            wr_en = ($urandom % 4) != 0;
            if ((3'(m_w - rb) != 3'd0) && ($urandom % 2 == 1)) rb = rb + 3'd1;
        end
        step();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag generator for the async FIFO; it produces the Gray pointer that the read domain synchronizes.
- Sits in the write clock domain next to the dual-port RAM write port.
- Consumes the read pointer after it has passed through the two-flop Gray synchronizer into the write domain.
- Produces the RAM write address, the registered Gray write pointer for the read domain, and a registered full flag.

Parameters:
- ADDR_W, 4: RAM address width. FIFO depth is 2^ADDR_W. Minimum legal value is 2.
- AF_MARGIN, 1: almost-full margin in entries. Used only when WPTR_LEVEL_EN is defined.

Ports:
- clk, input, 1: write-domain clock.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- wr_en, input, 1: write request from the producer.
- rptr_gray_sync, input, ADDR_W+1: read Gray pointer, already two-flop synchronized into clk.
- waddr, output, ADDR_W: RAM write address, equal to the low bits of the binary write pointer.
- wr_fire, output, 1: combinational write strobe to the RAM, wr_en & ~full.
- wptr_gray, output, ADDR_W+1: registered Gray write pointer, sent to the read-domain synchronizer.
- full, output, 1: registered FIFO full flag.
- wlevel, output, ADDR_W+1: fill level seen from the write side. Present only with WPTR_LEVEL_EN.
- almost_full, output, 1: registered almost-full flag. Present only with WPTR_LEVEL_EN.

Behaviour:
- State registers: wbin[ADDR_W:0], wptr_gray[ADDR_W:0], full. All clear to 0 on async reset.
  - Reset values of outputs: waddr=0, wptr_gray=0, full=0, wr_fire=0.
- Accept rule: a write is accepted when wr_en=1 and full=0.
  - wr_en while full=1 is ignored: no pointer change, wr_fire=0. There is no error flag.
- Pointer update:
  - bnext = wbin + accept, computed modulo 2^(ADDR_W+1), so it wraps naturally.
  - gnext = (bnext>>1) ^ bnext.
  - wbin <= bnext and wptr_gray <= gnext every clk.
  - Consequence: wptr_gray changes by exactly one bit per accepted write, and only one cycle after the accepted write. No combinational path from wr_en to wptr_gray.
- Full detection:
  - full <= (gnext == {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]}).
  - full is therefore high in the cycle after the accepting write that fills the FIFO.
  - full is pessimistic: it deasserts only once the advanced read pointer arrives through the synchronizer. No data loss is possible.
- Address: waddr = wbin[ADDR_W-1:0]. Write data is stored at waddr in the cycle wr_fire=1.
- Simultaneous events:
  - A rptr_gray_sync change in the same cycle as an accepted write: full is evaluated against the new rptr_gray_sync and gnext.
  - The FIFO can go from full to not-full and back to full in consecutive cycles.
- Reset mid-operation: all registers clear immediately (asynchronously). Pointers restart at 0. The read domain must be reset in the same reset event.
- No state machine beyond the pointer counter. Latency from wr_en to visible wptr_gray is 1 clk.

Optional Feature:
- Macro: WPTR_LEVEL_EN.
- Defined:
  - Convert rptr_gray_sync to binary (rbin) by XOR prefix from the MSB.
  - wlevel <= bnext - rbin, modulo 2^(ADDR_W+1), registered, reset 0.
  - almost_full <= ((bnext - rbin) >= 2^ADDR_W - AF_MARGIN), registered, reset 0.
  - wlevel is never greater than 2^ADDR_W.
- Undefined: wlevel and almost_full ports and their logic are absent. All other behaviour is identical.

Test Plan:
All tests use ADDR_W=2 (depth 4).
1. Reset: assert rst_n=0 asynchronously mid-cycle -> waddr=0, wptr_gray=3'b000, full=0 immediately.
2. Fill: rptr_gray_sync=000, wr_en=1 for 5 cycles.
   - wptr_gray sequence: 001, 011, 010, 110.
   - waddr sequence: 0, 1, 2, 3.
   - full=1 after the 4th write.
   - 5th request: wr_fire=0, wptr_gray holds 110.
3. Drain one: with full=1, set rptr_gray_sync=001 -> full=0 next cycle. One more write -> wptr_gray=111, full=1 again.
4. Wrap-around: perform 8 accepted writes while rptr_gray_sync tracks within 3 entries -> wbin wraps to 0, wptr_gray=000, waddr=0, full never set.
5. Simultaneous: full=1 with wr_en=1, and rptr_gray_sync advances in the same cycle -> that request is still rejected; the next cycle's write is accepted.
6. WPTR_LEVEL_EN defined, AF_MARGIN=1:
   - 3 writes with rptr_gray_sync=000 -> wlevel=3, almost_full=1.
   - 4th write -> wlevel=4, full=1.
   - rptr_gray_sync=011 (binary 2) -> wlevel=2, almost_full=0.
